dmem_responder: RTL

- Data-memory responder: the memory-side end of the CPU memory-stage load/store interface.
- Accepts one load or store request at a time via valid/ready handshake; performs byte/half/word access on an internal word-organised array.
- Returns formatted (sign/zero-extended) load data or a store acknowledge, with an error flag.
- Staging block ahead of the external DDR3 controller: latency and handshake already match a non-fixed-latency memory.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the memory stage and the data-memory responder
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - serialised byte/half/word load/store responder on a word-organised array
// Optional macro DMEM_WAIT_STATES_EN inserts WAIT_CYCLES wait states after every accepted request.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 4
) (
    input logic             i_clk,
    input logic             i_reset,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

`ifdef DMEM_WAIT_STATES_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, READ, RESP, WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
`endif

    state_t                state;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [2:0]            funct3_q;
    logic [1:0]            lane_q;
    logic [IDX_W-1:0]      idx_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  req_err;
    logic [IDX_W-1:0]      req_idx;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_word;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [3:0]            wr_be;
    logic [DATA_WIDTH-1:0] wr_word;

    assign accept  = bus.req_valid && req_ready_q;
    assign req_idx = bus.req_addr[IDX_W+1:2];

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Every upper address bit takes part in the range check so addresses never alias.
    always_comb begin
        req_err = ({2'b00, bus.req_addr[DATA_WIDTH-1:2]} >= DATA_WIDTH'(MEM_DEPTH));
        case (bus.req_funct3)
            3'b000:  ;
            3'b001:  if (bus.req_addr[0]) req_err = 1'b1;
            3'b010:  if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
            3'b100:  if (bus.req_we) req_err = 1'b1;
            3'b101:  if (bus.req_we || bus.req_addr[0]) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // Store data arrives right-aligned; replicate it so every enabled lane sees its byte.
    always_comb begin
        req_be   = 4'b0000;
        req_word = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                req_be   = 4'b0001 << bus.req_addr[1:0];
                req_word = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                req_be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                req_word = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   req_be = 4'b1111;
            default: req_be = 4'b0000;
        endcase
    end

`ifdef DMEM_WAIT_STATES_EN
    logic [CNT_W-1:0]      wait_cnt;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] word_q;

    assign wr_en   = (WAIT_CYCLES == 0) ? (accept && bus.req_we && !req_err)
                                        : (state == WAIT && wait_cnt == '0 && we_q && !rsp_err_q);
    assign wr_idx  = (WAIT_CYCLES == 0) ? req_idx  : idx_q;
    assign wr_be   = (WAIT_CYCLES == 0) ? req_be   : be_q;
    assign wr_word = (WAIT_CYCLES == 0) ? req_word : word_q;
`else
    assign wr_en   = accept && bus.req_we && !req_err;
    assign wr_idx  = req_idx;
    assign wr_be   = req_be;
    assign wr_word = req_word;
`endif

    function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [2:0] f3,
                                                       input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'h0, b};
            3'b101:  fmt_load = {16'h0, h};
            default: fmt_load = w;
        endcase
    endfunction

    // The array has no reset; a write never lands on an edge where reset is asserted.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_reset) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            idx_q       <= '0;
`ifdef DMEM_WAIT_STATES_EN
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            word_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        rsp_err_q   <= req_err;
                        rsp_rdata_q <= '0;
                        funct3_q    <= bus.req_funct3;
                        lane_q      <= bus.req_addr[1:0];
                        idx_q       <= req_idx;
`ifdef DMEM_WAIT_STATES_EN
                        we_q        <= bus.req_we;
                        be_q        <= req_be;
                        word_q      <= req_word;
                        // Counter holds the remaining wait cycles minus one; exit on zero.
                        if (WAIT_CYCLES != 0) begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            state <= bus.req_we ? RESP : READ;
                        end
`else
                        state       <= bus.req_we ? RESP : READ;
`endif
                    end
                end
`ifdef DMEM_WAIT_STATES_EN
                WAIT: begin
                    if (wait_cnt == '0) state <= we_q ? RESP : READ;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
`endif
                READ: begin
                    if (!rsp_err_q) rsp_rdata_q <= fmt_load(mem[idx_q], funct3_q, lane_q);
                    state <= RESP;
                end
                RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
